byte_serializer_tx: RTL and testbench
=====================================

Name: byte_serializer_tx

Overview:
Parallel-to-serial transmitter. It takes WIDTH-bit words from a parallel register stage through a valid/ready handshake and shifts them out one bit at a time. Each bit is held for CLKS_PER_BIT clocks, with a frame-qualifier output. A one-word holding register lets the next word be accepted while the current word is shifting, so consecutive words stream with no gap.

Parameters:
WIDTH, 8, word width in bits; must be at least 2.
CLKS_PER_BIT, 4, clocks each serial bit is held; must be at least 1.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
in_data  input  WIDTH  parallel word to transmit.
in_valid  input  1  in_data is valid.
in_ready  output  1  holding register empty; a word is accepted on a rising edge where in_valid=1 and in_ready=1.
sdata  output  1  serial data; forced to 0 whenever sframe=0.
sframe  output  1  high during every clock in which sdata carries a frame bit.
tx_done  output  1  one-clock pulse on the final clock of each word's last bit.
busy  output  1  high when the state is SHIFT or the holding register is full.

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE; hold_full=0; hold, shift register, bit counter and divider counter all 0.
  - Outputs: sdata=0, sframe=0, tx_done=0, busy=0, in_ready=1.
- Outputs are combinational from registered state only; there is no in_valid-to-in_ready path.
- in_ready = !hold_full. An accept on edge N loads hold<=in_data and sets hold_full=1 at edge N.
- State IDLE:
  - If hold_full=1, the next edge loads shift<=hold, clears hold_full, zeroes both counters and enters SHIFT.
  - Result: first serial bit appears exactly 1 clock after the accepting edge.
- State SHIFT:
  - sframe=1; sdata = shift[WIDTH-1] when MSB_FIRST=1, otherwise shift[0].
  - Divider counts 0..CLKS_PER_BIT-1. On wrap, the shift register shifts by one (toward the output end, zero fill) and the bit counter increments.
  - A word occupies exactly WIDTH*CLKS_PER_BIT clocks.
- Last-bit, last-divider clock:
  - tx_done=1 for that one clock.
  - If hold_full=1 at that edge: reload shift<=hold, clear hold_full, zero the counters and stay in SHIFT. sframe remains high continuously, with no idle clock between words.
  - Otherwise: go to IDLE.
- Simultaneous events:
  - An accept cannot coincide with hold being emptied into shift, because in_ready is 0 whenever hold_full=1.
  - A word accepted while in SHIFT waits in hold.
  - A word accepted during the final clock of a frame (hold empty) is loaded at the following edge via IDLE, giving a one-clock gap.
- CLKS_PER_BIT=1: one bit per clock; the divider is effectively constant 0.
- Reset mid-frame: the word in flight and any held word are discarded. Outputs go to reset values immediately. tx_done does not pulse for the aborted word.
- in_data is sampled only on the accepting edge; later changes have no effect.

Test Plan:
1. Reset/idle (WIDTH=8, CLKS_PER_BIT=2, MSB_FIRST=1): rst=0 for 5 clocks, then 1 with in_valid=0 -> sframe=0, sdata=0, tx_done=0, busy=0, in_ready=1 throughout.
2. Single word: send in_data=8'hAA, one accept -> sframe rises 1 clock later and stays high 16 clocks; sdata=1,1,0,0,1,1,0,0,... (pairs); tx_done pulses on the 16th clock; back to IDLE.
3. Back-to-back: accept 8'hFF, then 8'h55 while in_ready returns 1 -> sframe high 32 consecutive clocks; sdata=1 for 16 clocks, then 0,0,1,1,... for 16 clocks; two tx_done pulses, 16 clocks apart.
4. Backpressure: accept 8'h0F, then 8'hF0 during SHIFT, then hold in_valid=1 with 8'h33 -> in_ready=0 until 8'hF0 moves to shift; 8'h33 is accepted only then; three words are sent in order with no corruption.
5. LSB-first (MSB_FIRST=0, CLKS_PER_BIT=1): send 8'h01 -> sdata=1,0,0,0,0,0,0,0 over 8 consecutive clocks, with tx_done on the 8th.
6. Async reset mid-frame: drop rst between clk edges during the 3rd bit of 8'hC3 -> sframe, sdata and busy go to 0 at once, in_ready=1, and there is no tx_done. After release, a new 8'h81 transmits correctly from bit 0 of the frame.

Source files
------------

// File: rtl/byte_serializer_tx.sv
// byte_serializer_tx
// Parallel-to-serial transmitter. Words enter through a valid/ready handshake
// into a one-word holding register, then shift out one bit at a time, each bit
// held for CLKS_PER_BIT clocks. The holding register refills while a word is
// shifting, so consecutive words stream without an idle clock.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   in_data   parallel word to transmit (WIDTH bits)
//   in_valid  in_data is valid
//   in_ready  holding register empty; accept on edge with in_valid & in_ready
//   sdata     serial data, 0 whenever sframe is 0
//   sframe    high while sdata carries a frame bit
//   tx_done   one-clock pulse on the final clock of a word's last bit
//   busy      shifting or holding register full
module byte_serializer_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int MSB_FIRST    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sdata,
  output logic             sframe,
  output logic             tx_done,
  output logic             busy
);

  localparam int BIT_W = $clog2(WIDTH);
  // Keep the divider at least one bit wide even when CLKS_PER_BIT is 1.
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [WIDTH-1:0]   hold_r, hold_nxt_s;
  logic               hold_full_r, hold_full_nxt_s;
  logic [WIDTH-1:0]   shift_r, shift_nxt_s;
  logic [BIT_W-1:0]   bit_cnt_r, bit_cnt_nxt_s;
  logic [DIV_W-1:0]   div_cnt_r, div_cnt_nxt_s;

  logic               accept_s;
  logic               bit_end_s;
  logic               word_end_s;

  assign accept_s   = in_valid & ~hold_full_r;
  assign bit_end_s  = (div_cnt_r == DIV_LAST);
  assign word_end_s = (state_r == ST_SHIFT) && bit_end_s && (bit_cnt_r == BIT_LAST);

  // Outputs decode registered state only; nothing depends on in_valid.
  assign in_ready = ~hold_full_r;
  assign sframe   = (state_r == ST_SHIFT);
  assign sdata    = (state_r == ST_SHIFT) &
                    ((MSB_FIRST != 0) ? shift_r[WIDTH-1] : shift_r[0]);
  assign tx_done  = word_end_s;
  assign busy     = (state_r == ST_SHIFT) | hold_full_r;

  // Next-state, shifter, counter and holding-register logic.
  always_comb begin
    state_nxt_s     = state_r;
    hold_nxt_s      = hold_r;
    hold_full_nxt_s = hold_full_r;
    shift_nxt_s     = shift_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    div_cnt_nxt_s   = div_cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (hold_full_r) begin
          shift_nxt_s     = hold_r;
          hold_full_nxt_s = 1'b0;
          bit_cnt_nxt_s   = '0;
          div_cnt_nxt_s   = '0;
          state_nxt_s     = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (word_end_s) begin
          bit_cnt_nxt_s = '0;
          div_cnt_nxt_s = '0;
          if (hold_full_r) begin
            // Reload from hold so sframe stays high across the word boundary.
            shift_nxt_s     = hold_r;
            hold_full_nxt_s = 1'b0;
            state_nxt_s     = ST_SHIFT;
          end else begin
            shift_nxt_s = '0;
            state_nxt_s = ST_IDLE;
          end
        end else if (bit_end_s) begin
          // Move the next bit toward the output end, zero fill.
          if (MSB_FIRST != 0) begin
            shift_nxt_s = {shift_r[WIDTH-2:0], 1'b0};
          end else begin
            shift_nxt_s = {1'b0, shift_r[WIDTH-1:1]};
          end
          bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
          div_cnt_nxt_s = '0;
        end else begin
          div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // An accept never coincides with hold being drained: that needs hold_full=1.
    if (accept_s) begin
      hold_nxt_s      = in_data;
      hold_full_nxt_s = 1'b1;
    end else begin
      hold_nxt_s = hold_nxt_s;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      shift_r     <= '0;
      bit_cnt_r   <= '0;
      div_cnt_r   <= '0;
    end else begin
      state_r     <= state_nxt_s;
      hold_r      <= hold_nxt_s;
      hold_full_r <= hold_full_nxt_s;
      shift_r     <= shift_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      div_cnt_r   <= div_cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_byte_serializer_tx.sv
module tb_byte_serializer_tx;

  localparam int W = 8;
  localparam int N = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_data;
  logic       in_valid_a, in_valid_b;
  logic       ready_a, sdata_a, sframe_a, done_a, busy_a;
  logic       ready_b, sdata_b, sframe_b, done_b, busy_b;

  byte_serializer_tx #(.WIDTH(8), .CLKS_PER_BIT(2), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_a),
    .in_ready(ready_a), .sdata(sdata_a), .sframe(sframe_a),
    .tx_done(done_a), .busy(busy_a)
  );

  byte_serializer_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_b),
    .in_ready(ready_b), .sdata(sdata_b), .sframe(sframe_b),
    .tx_done(done_b), .busy(busy_b)
  );

  int sel;
  int cpb;
  int msb_first;
  int now;
  int last_end;
  int n_assert;
  int n_fail;

  // Expected per-cycle behaviour, indexed by cycle number.
  logic m_frame[N];
  logic m_data[N];
  logic m_done[N];
  logic m_ready[N];
  logic m_busy[N];

  logic o_ready, o_data, o_frame, o_done, o_busy;
  always_comb begin
    if (sel == 0) begin
      o_ready = ready_a; o_data = sdata_a; o_frame = sframe_a;
      o_done  = done_a;  o_busy = busy_a;
    end else begin
      o_ready = ready_b; o_data = sdata_b; o_frame = sframe_b;
      o_done  = done_b;  o_busy = busy_b;
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, now, obs, exp);
    end
  endtask

  task automatic model_clear(input int from);
    for (int k = from; k < N; k++) begin
      m_frame[k] = 1'b0; m_data[k] = 1'b0; m_done[k] = 1'b0;
      m_ready[k] = 1'b1; m_busy[k] = 1'b0;
    end
    last_end = -1;
  endtask

  // A word accepted at edge now+1 starts the clock after that edge, or right
  // after the previous word finishes, whichever is later.
  task automatic model_accept(input logic [7:0] word, output int s);
    int e;
    int b;
    int k;
    e = now + 1;
    s = (now + 2 > last_end + 1) ? now + 2 : last_end + 1;
    for (int j = e; j < s; j++) begin
      m_ready[j] = 1'b0;
      m_busy[j]  = 1'b1;
    end
    for (int i = 0; i < W * cpb; i++) begin
      b = i / cpb;
      k = s + i;
      m_frame[k] = 1'b1;
      m_busy[k]  = 1'b1;
      m_data[k]  = (msb_first != 0) ? word[W-1-b] : word[b];
      m_done[k]  = (i == W * cpb - 1);
    end
    last_end = s + W * cpb - 1;
  endtask

  // Check the current cycle, drive inputs, advance to the next cycle.
  task automatic step(input logic v, input logic [7:0] d, output logic acc, output int s);
    chk("sframe", o_frame, m_frame[now]);
    chk("sdata", o_data, m_data[now]);
    chk("tx_done", o_done, m_done[now]);
    chk("in_ready", o_ready, m_ready[now]);
    chk("busy", o_busy, m_busy[now]);
    in_data    = d;
    in_valid_a = (sel == 0) ? v : 1'b0;
    in_valid_b = (sel == 1) ? v : 1'b0;
    acc = v && rst && m_ready[now];
    s = -1;
    if (acc) model_accept(d, s);
    @(posedge clk);
    now++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    int s;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, acc, s);
  endtask

  task automatic send_word(input logic [7:0] d, output int s);
    logic acc;
    int cnt;
    acc = 1'b0;
    cnt = 0;
    s = -1;
    while (!acc && cnt < 100) begin
      step(1'b1, d, acc, s);
      cnt++;
    end
    if (!acc) chk("accept_timeout", acc, 1'b1);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic random_phase(input int n);
    logic acc;
    int s;
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 8'($urandom), acc, s);
  endtask

  initial begin
    int s;
    n_assert = 0;
    n_fail = 0;
    sel = 0; cpb = 2; msb_first = 1;
    rst = 1'b0;
    in_data = 8'h00;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    now = 0;
    model_clear(0);
    @(negedge clk);

    // Reset held, then released with nothing offered.
    idle(5);
    rst = 1'b1;
    idle(3);

    // Single word.
    send_word(8'hAA, s);
    idle(20);

    // Back-to-back words.
    send_word(8'hFF, s);
    send_word(8'h55, s);
    idle(36);

    // Backpressure: the third word waits while the second sits in hold.
    send_word(8'h0F, s);
    send_word(8'hF0, s);
    send_word(8'h33, s);
    idle(60);

    // Asynchronous reset during the third bit of a word.
    send_word(8'hC3, s);
    while (now < s + 4) idle(1);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_sframe", o_frame, 1'b0);
    chk("rst_sdata", o_data, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_in_ready", o_ready, 1'b1);
    chk("rst_tx_done", o_done, 1'b0);
    model_clear(now);
    idle(2);
    rst = 1'b1;
    idle(2);
    send_word(8'h81, s);
    idle(20);

    random_phase(150);
    idle(40);

    // LSB-first, one clock per bit.
    rst = 1'b0;
    model_clear(now);
    sel = 1; cpb = 1; msb_first = 0;
    idle(2);
    rst = 1'b1;
    idle(2);
    send_word(8'h01, s);
    idle(10);
    random_phase(100);
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
